pc_sequencer: RTL and testbench

Next-PC controller for the single-cycle RV32I core. Each cycle it decides the value presented on `PCnext` of the existing `Program_counter` register: sequential (+4), branch, jump, trap redirect, or hold. It runs a small control FSM covering boot, run, misaligned-target trap and halt/resume, and keeps a retired-instruction counter. It sits between decode/branch-compare logic and `Program_counter`, and reads that register's `PCout` back as `pc_in`.

---
 rtl/pc_sequencer_pkg.sv | 34 +++
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer_next_pc_mux.sv | 29 ++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM states, PC select
// encoding, default vectors and the misaligned-target predicate.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SEL_RESET  = 3'd0,
        SEL_HOLD   = 3'd1,
        SEL_SEQ    = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_BRANCH = 3'd4,
        SEL_TRAP   = 3'd5
    } pc_sel_e;

    localparam logic [31:0] PC_INC                  = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR    = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR     = 32'h0000_0100;
    localparam logic [31:0] MCAUSE_IADDR_MISALIGNED = 32'd0;

    // Jump targets have bit 0 cleared before the check, so only bit 1 matters there.
    function automatic logic target_misaligned(input logic        branch_taken,
                                               input logic [31:0] branch_target,
                                               input logic        jump,
                                               input logic [31:0] jump_target);
        return (branch_taken && (branch_target[1:0] != 2'b00)) || (jump && jump_target[1]);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/branch-side bundle of the next-PC sequencer; clk and rst stay outside.
interface pc_sequencer_if;
    logic [31:0] pc_in;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc_next;
    logic        retire;
    logic [31:0] instret;
    logic [31:0] mepc;
    logic        trap_pending;
    logic        halted;

    modport master (
        output pc_in, imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, halt_req, resume,
        input  pc_next, retire, instret, mepc, trap_pending, halted
    );

    modport slave (
        input  pc_in, imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, halt_req, resume,
        output pc_next, retire, instret, mepc, trap_pending, halted
    );
endinterface

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC selector driven by the already priority-encoded select.
module next_pc_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  pc_sel_e     sel_i,
    input  logic [31:0] pc_in_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] pc_next_o
);

    // Select the next PC source.
    always_comb begin
        pc_next_o = pc_in_i;
        case (sel_i)
            SEL_RESET:  pc_next_o = RESET_VECTOR;
            SEL_HOLD:   pc_next_o = pc_in_i;
            SEL_SEQ:    pc_next_o = pc_in_i + PC_INC;
            SEL_JUMP:   pc_next_o = jump_target_i & ~32'd1;
            SEL_BRANCH: pc_next_o = branch_target_i;
            SEL_TRAP:   pc_next_o = TRAP_VECTOR;
            default:    pc_next_o = pc_in_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot/run/trap/halt FSM, retired-instruction counter and
// faulting-PC capture around a combinational next-PC mux.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] mepc_q, mepc_d;
    pc_sel_e     sel_s;
    logic        retire_s;
    logic        misaligned_s;

    assign misaligned_s = target_misaligned(bus.branch_taken, bus.branch_target,
                                            bus.jump, bus.jump_target);

    // Next-state, PC select and retire decision.
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        sel_s    = SEL_HOLD;
        retire_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                sel_s   = SEL_RESET;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.imem_ready || bus.stall) begin
                    sel_s = SEL_HOLD;
                end else if (misaligned_s) begin
                    sel_s   = SEL_HOLD;
                    mepc_d  = bus.pc_in;
                    state_d = ST_TRAP;
                end else if (bus.halt_req) begin
                    sel_s    = SEL_HOLD;
                    retire_s = 1'b1;
                    state_d  = ST_HALT;
                end else if (bus.jump) begin
                    sel_s    = SEL_JUMP;
                    retire_s = 1'b1;
                end else if (bus.branch_taken) begin
                    sel_s    = SEL_BRANCH;
                    retire_s = 1'b1;
                end else begin
                    sel_s    = SEL_SEQ;
                    retire_s = 1'b1;
                end
            end
            ST_TRAP: begin
                sel_s   = SEL_TRAP;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                if (bus.resume) begin
                    sel_s   = SEL_SEQ;
                    state_d = ST_RUN;
                end else begin
                    sel_s = SEL_HOLD;
                end
            end
            default: begin
                sel_s   = SEL_RESET;
                state_d = ST_BOOT;
            end
        endcase
    end

    assign instret_d = instret_q + {31'd0, retire_s};

    // State, retire counter and faulting-PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            instret_q <= 32'd0;
            mepc_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            mepc_q    <= mepc_d;
        end
    end

    next_pc_mux #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_mux (
        .sel_i           (sel_s),
        .pc_in_i         (bus.pc_in),
        .branch_target_i (bus.branch_target),
        .jump_target_i   (bus.jump_target),
        .pc_next_o       (bus.pc_next)
    );

    assign bus.retire       = retire_s;
    assign bus.instret      = instret_q;
    assign bus.mepc         = mepc_q;
    assign bus.trap_pending = (state_q == ST_TRAP);
    assign bus.halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int M_BOOT = 0, M_RUN = 1, M_TRAP = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: mode, counter, faulting PC, and the PC register contents.
    int          m_mode;
    logic [31:0] m_instret, m_mepc, m_pc;
    int          e_mode;
    logic [31:0] e_pc, e_mepc;
    logic        e_ret;
    logic [31:0] bt, jt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic rdy, input logic stl, input logic br, input logic [31:0] btg,
                          input logic jmp, input logic [31:0] jtg, input logic hlt, input logic res);
        bus.imem_ready    = rdy;
        bus.stall         = stl;
        bus.branch_taken  = br;
        bus.branch_target = btg;
        bus.jump          = jmp;
        bus.jump_target   = jtg;
        bus.halt_req      = hlt;
        bus.resume        = res;
    endtask

    task automatic model_eval();
        logic bad;
        e_pc   = bus.pc_in;
        e_ret  = 1'b0;
        e_mode = m_mode;
        e_mepc = m_mepc;
        bad = (bus.branch_taken && ((bus.branch_target % 32'd4) != 32'd0)) ||
              (bus.jump && ((((bus.jump_target >> 1) << 1) % 32'd4) != 32'd0));
        if (m_mode == M_BOOT) begin
            e_pc = RV; e_mode = M_RUN;
        end else if (m_mode == M_TRAP) begin
            e_pc = TV; e_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (bus.resume) begin e_pc = bus.pc_in + 32'd4; e_mode = M_RUN; end
        end else if (!bus.imem_ready || bus.stall) begin
            e_pc = bus.pc_in;
        end else if (bad) begin
            e_mepc = bus.pc_in; e_mode = M_TRAP;
        end else if (bus.halt_req) begin
            e_ret = 1'b1; e_mode = M_HALT;
        end else if (bus.jump) begin
            e_pc = (bus.jump_target >> 1) << 1; e_ret = 1'b1;
        end else if (bus.branch_taken) begin
            e_pc = bus.branch_target; e_ret = 1'b1;
        end else begin
            e_pc = bus.pc_in + 32'd4; e_ret = 1'b1;
        end
    endtask

    task automatic eval_check(input string tag);
        model_eval();
        #1;
        chk({tag, ".pc_next"}, bus.pc_next, e_pc);
        chk({tag, ".retire"}, {31'd0, bus.retire}, {31'd0, e_ret});
        chk({tag, ".instret"}, bus.instret, m_instret);
        chk({tag, ".mepc"}, bus.mepc, m_mepc);
        chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, (m_mode == M_HALT)});
        chk({tag, ".trap"}, {31'd0, bus.trap_pending}, {31'd0, (m_mode == M_TRAP)});
    endtask

    task automatic advance();
        @(posedge clk);
        m_pc   = e_pc;
        m_mode = e_mode;
        m_mepc = e_mepc;
        if (e_ret) m_instret = m_instret + 32'd1;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.pc_in = 32'h0;
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc_next", bus.pc_next, RV);
        chk("rst.retire", {31'd0, bus.retire}, 32'd0);
        chk("rst.trap", {31'd0, bus.trap_pending}, 32'd0);
        chk("rst.halted", {31'd0, bus.halted}, 32'd0);
        chk("rst.instret", bus.instret, 32'd0);
        chk("rst.mepc", bus.mepc, 32'd0);

        rst = 1'b0;
        m_mode = M_BOOT; m_instret = 32'd0; m_mepc = 32'd0; m_pc = RV;
        for (int i = 0; i < 4; i++) begin
            bus.pc_in = m_pc;
            eval_check("seq");
            chk("seq.const", bus.pc_next, 32'(i * 4));
            advance();
        end
        chk("seq.instret3", bus.instret, 32'd3);

        bus.pc_in = 32'h10;
        set_in(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        eval_check("branch");
        chk("branch.target", bus.pc_next, 32'h40);
        chk("branch.retire", {31'd0, bus.retire}, 32'd1);
        advance();
        set_in(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        eval_check("stall");
        chk("stall.hold", bus.pc_next, 32'h10);
        chk("stall.retire", {31'd0, bus.retire}, 32'd0);
        advance();

        bus.pc_in = 32'h20;
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h81, 1'b0, 1'b0);
        eval_check("jump");
        chk("jump.bit0", bus.pc_next, 32'h80);
        advance();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h82, 1'b0, 1'b0);
        eval_check("jmis");
        chk("jmis.retire", {31'd0, bus.retire}, 32'd0);
        advance();
        chk("jmis.mepc", bus.mepc, 32'h20);
        chk("jmis.trap", {31'd0, bus.trap_pending}, 32'd1);
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        eval_check("trap");
        chk("trap.vector", bus.pc_next, 32'h100);
        advance();
        bus.pc_in = 32'h100;
        eval_check("post_trap");
        chk("post_trap.run", bus.pc_next, 32'h104);
        advance();

        bus.pc_in = 32'h30;
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        eval_check("halt");
        chk("halt.retire", {31'd0, bus.retire}, 32'd1);
        advance();
        bus.halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            eval_check("halted");
            chk("halted.flag", {31'd0, bus.halted}, 32'd1);
            chk("halted.hold", bus.pc_next, 32'h30);
            advance();
        end
        bus.resume = 1'b1;
        eval_check("resume");
        chk("resume.pc", bus.pc_next, 32'h34);
        advance();
        bus.resume = 1'b0;
        bus.pc_in  = 32'h34;
        eval_check("resumed");
        chk("resumed.run", bus.pc_next, 32'h38);
        advance();

        bus.pc_in = 32'h50;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eval_check("imem_wait");
            chk("imem_wait.hold", bus.pc_next, 32'h50);
            advance();
        end
        bus.imem_ready = 1'b1;

        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        bus.pc_in = 32'h54;
        eval_check("wrap");
        advance();
        chk("wrap.instret", bus.instret, 32'd0);

        for (int i = 0; i < 400; i++) begin
            bus.pc_in = m_pc;
            bt = $urandom();
            jt = $urandom();
            if ($urandom_range(7) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(7) != 0) jt[1] = 1'b0;
            bus.jump = ($urandom_range(5) == 0);
            if (bus.jump) bt[1:0] = 2'b00;
            bus.imem_ready    = ($urandom_range(7) != 0);
            bus.stall         = ($urandom_range(7) == 0);
            bus.branch_taken  = ($urandom_range(3) == 0);
            bus.branch_target = bt;
            bus.jump_target   = jt;
            bus.halt_req      = ($urandom_range(15) == 0);
            bus.resume        = ($urandom_range(2) == 0);
            eval_check("rand");
            advance();
        end

        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4 && m_mode != M_RUN; k++) begin
            bus.pc_in = m_pc;
            eval_check("to_run");
            advance();
        end
        bus.pc_in = 32'h60;
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h62, 1'b0, 1'b0);
        eval_check("trap2");
        advance();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        eval_check("trap2.t");
        advance();
        bus.pc_in = 32'h100;
        bus.halt_req = 1'b1;
        eval_check("halt2");
        advance();
        bus.halt_req = 1'b0;
        eval_check("halt2.h");
        chk("halt2.mepc", bus.mepc, 32'h60);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.state", 32'(dut.state_q), 32'(ST_BOOT));
        chk("arst.pc_next", bus.pc_next, RV);
        chk("arst.retire", {31'd0, bus.retire}, 32'd0);
        chk("arst.halted", {31'd0, bus.halted}, 32'd0);
        chk("arst.trap", {31'd0, bus.trap_pending}, 32'd0);
        chk("arst.mepc", bus.mepc, 32'd0);
        chk("arst.instret", bus.instret, 32'd0);
        repeat (2) @(posedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
